// File: rtl/led_pkg.sv
// Shared types and helpers for the LED blink arbiter.
// Holds the FSM state type and the tick-period derivation.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF,
    GAP
  } state_t;

  function automatic int clog2_safe(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int tpt_of(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  localparam int DEF_TPT = tpt_of(50000000, 1000);

endpackage

// File: rtl/led_tick_gen.sv
// Tick prescaler: one-cycle tick every TPT clocks.
// clr restarts the period so a phase can begin on a clean boundary.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int TPT = DEF_TPT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = clog2_safe(TPT);
  localparam logic [PW-1:0] LAST = PW'(TPT - 1);

  logic [PW-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter sharing one LED between N_REQ blink requesters.
// Define LED_BLINK_ABORT_EN to add an abort input that cuts a burst to GAP.
module led_blink_arbiter
  import led_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 1000,
  parameter int N_REQ     = 4,
  parameter int CNT_W     = 4,
  parameter int ON_TICKS  = 250,
  parameter int OFF_TICKS = 250,
  parameter int GAP_TICKS = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*CNT_W-1:0]   req_count,
`ifdef LED_BLINK_ABORT_EN
  input  logic                     abort,
`endif
  output logic [N_REQ-1:0]         req_ack,
  output logic                     led_out,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] active_id
);

  localparam int TPT  = tpt_of(CLK_HZ, TICK_HZ);
  localparam int ID_W = $clog2(N_REQ);
  localparam int M1   = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int PMAX = (M1 > GAP_TICKS) ? M1 : GAP_TICKS;
  localparam int PH_W = clog2_safe(PMAX);

  localparam logic [PH_W-1:0] ON_L  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0] OFF_L = PH_W'(OFF_TICKS - 1);
  localparam logic [PH_W-1:0] GAP_L = PH_W'(GAP_TICKS - 1);

  state_t          r_state;
  logic [CNT_W-1:0] r_rem;
  logic [PH_W-1:0] r_phase;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_id;
  logic            r_led;

  logic            w_tick;
  logic            w_clr;
  logic            w_any;
  logic            w_grant;
  logic            w_done;
  logic            w_abort;
  logic [ID_W-1:0] w_idx;
  logic [CNT_W-1:0] w_cnt;
  logic [PH_W-1:0] w_last;

  // First valid requester at or after the RR pointer, with wrap.
  always_comb begin
    int j;
    j     = 0;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(r_ptr) + k) % N_REQ;
      if (req_valid[j]) begin
        w_any = 1'b1;
        w_idx = ID_W'(j);
      end
    end
  end

  assign w_cnt   = req_count[w_idx*CNT_W +: CNT_W];
  assign w_grant = (r_state == IDLE) && w_any && !rst;

  always_comb begin
    req_ack = '0;
    if (w_grant) begin
      req_ack[w_idx] = 1'b1;
    end
  end

  always_comb begin
    w_last = '0;
    case (r_state)
      ON:      w_last = ON_L;
      OFF:     w_last = OFF_L;
      GAP:     w_last = GAP_L;
      default: w_last = '0;
    endcase
  end

  assign w_done = w_tick && (r_state != IDLE) && (r_phase == w_last);

`ifdef LED_BLINK_ABORT_EN
  assign w_abort = abort && ((r_state == ON) || (r_state == OFF));
`else
  assign w_abort = 1'b0;
`endif

  assign w_clr = w_grant || w_done || w_abort;

  led_tick_gen #(
    .TPT (TPT)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_led   <= 1'b0;
      r_ptr   <= '0;
      r_id    <= '0;
      r_rem   <= '0;
      r_phase <= '0;
    end else begin
      if (w_clr) begin
        r_phase <= '0;
      end else if (w_tick && (r_state != IDLE)) begin
        r_phase <= r_phase + 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_id  <= w_idx;
            r_rem <= w_cnt;
            r_ptr <= (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            if (w_cnt != '0) begin
              r_state <= ON;
              r_led   <= 1'b1;
            end
          end
        end
        ON: begin
          if (w_abort) begin
            r_state <= GAP;
            r_led   <= 1'b0;
          end else if (w_done) begin
            r_rem   <= r_rem - 1'b1;
            r_led   <= 1'b0;
            r_state <= (r_rem == CNT_W'(1)) ? GAP : OFF;
          end
        end
        OFF: begin
          if (w_abort) begin
            r_state <= GAP;
          end else if (w_done) begin
            r_state <= ON;
            r_led   <= 1'b1;
          end
        end
        GAP: begin
          if (w_done) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_led   <= 1'b0;
        end
      endcase
    end
  end

  assign led_out   = r_led;
  assign busy      = (r_state != IDLE);
  assign active_id = r_id;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed bench for led_blink_arbiter with TPT=10, ON=2, OFF=3, GAP=4.
// A 1-blink burst spans 60 cycles, so back-to-back grants are 61 apart.
module tb_led_blink_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_count;
  logic [3:0]  req_ack;
  logic        led_out;
  logic        busy;
  logic [1:0]  active_id;
`ifdef LED_BLINK_ABORT_EN
  logic        abort;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_blink_arbiter #(
    .CLK_HZ    (1000),
    .TICK_HZ   (100),
    .N_REQ     (4),
    .CNT_W     (4),
    .ON_TICKS  (2),
    .OFF_TICKS (3),
    .GAP_TICKS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_count (req_count),
`ifdef LED_BLINK_ABORT_EN
    .abort     (abort),
`endif
    .req_ack   (req_ack),
    .led_out   (led_out),
    .busy      (busy),
    .active_id (active_id)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) cyc();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] exp_id [5];

  initial begin
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1;
    req_valid = '0;
    req_count = '0;
`ifdef LED_BLINK_ABORT_EN
    abort = 1'b0;
`endif
    adv(2);
    chk("rst_led", led_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_id", active_id, 0);
    rst = 1'b0;
    cyc();

    // 1: two blinks on requester 0
    req_count = 16'h0002;
    req_valid = 4'b0001;
    #1 chk("t1_ack", req_ack, 4'b0001);
    cyc();
    req_valid = 4'b0000;
    chk("t1_ack_end", req_ack, 0);
    chk("t1_on1_s", led_out, 1);
    chk("t1_busy", busy, 1);
    adv(19); chk("t1_on1_e", led_out, 1);
    adv(1);  chk("t1_off_s", led_out, 0);
    adv(29); chk("t1_off_e", led_out, 0);
    adv(1);  chk("t1_on2_s", led_out, 1);
    adv(19); chk("t1_on2_e", led_out, 1);
    adv(1);  chk("t1_gap_s", led_out, 0);
    adv(39); chk("t1_gap_e", led_out, 0);
    chk("t1_busy_e", busy, 1);
    adv(1);  chk("t1_idle", busy, 0);
    chk("t1_id", active_id, 0);

    // 2: all four requesting, one blink each
    rst = 1'b1;
    cyc();
    chk("t2_rst_busy", busy, 0);
    rst = 1'b0;
    req_count = 16'h1111;
    req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk("t2_ack", req_ack, 32'd1 << exp_id[g]);
      cyc();
      if (g == 4) req_valid = 4'b0000;
      chk("t2_id", active_id, exp_id[g]);
      if (g < 4) begin
        adv(59);
        chk("t2_gap_noack", req_ack, 0);
        chk("t2_gap_busy", busy, 1);
        cyc();
      end
    end
    adv(60);
    chk("t2_idle", busy, 0);

    // 3: zero-count request, then immediate next grant
    req_count = 16'h1011;
    req_valid = 4'b0100;
    #1 chk("t3_ack", req_ack, 4'b0100);
    cyc();
    req_valid = 4'b0001;
    chk("t3_busy", busy, 0);
    chk("t3_led", led_out, 0);
    chk("t3_id", active_id, 2);
    #1 chk("t3_ack2", req_ack, 4'b0001);
    cyc();
    req_valid = 4'b0000;
    chk("t3_led2", led_out, 1);
    chk("t3_id2", active_id, 0);
    adv(60);
    chk("t3_idle", busy, 0);

    // 4: reset mid-ON of a 3-blink burst clears the RR pointer
    req_count = 16'h1311;
    req_valid = 4'b0100;
    #1 chk("t4_ack", req_ack, 4'b0100);
    cyc();
    req_valid = 4'b0000;
    adv(14);
    chk("t4_on", led_out, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t4_rst_led", led_out, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_id", active_id, 0);
    req_count = 16'h1111;
    req_valid = 4'b1010;
    #1 chk("t4_rr_ack", req_ack, 4'b0010);
    cyc();
    req_valid = 4'b0000;
    chk("t4_rr_id", active_id, 1);
    adv(60);
    chk("t4_idle", busy, 0);

    // 5: request raised during GAP waits for IDLE
    req_count = 16'h2111;
    req_valid = 4'b0001;
    #1 chk("t5_ack", req_ack, 4'b0001);
    cyc();
    req_valid = 4'b0000;
    adv(24);
    req_valid = 4'b1000;
    #1 chk("t5_gap_ack", req_ack, 0);
    adv(35);
    chk("t5_gap_end_ack", req_ack, 0);
    chk("t5_gap_end_busy", busy, 1);
    cyc();
    chk("t5_late_ack", req_ack, 4'b1000);
    cyc();
    req_valid = 4'b0000;
    chk("t5_led", led_out, 1);
    chk("t5_id", active_id, 3);
    adv(110);
    chk("t5_idle", busy, 0);

`ifdef LED_BLINK_ABORT_EN
    // 6: abort in the second ON goes straight to a full GAP
    req_count = 16'h0003;
    req_valid = 4'b0001;
    #1 chk("t6_ack", req_ack, 4'b0001);
    cyc();
    req_valid = 4'b0000;
    adv(54);
    chk("t6_on2", led_out, 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t6_ab_led", led_out, 0);
    chk("t6_ab_busy", busy, 1);
    adv(39);
    chk("t6_gap_end", busy, 1);
    adv(1);
    chk("t6_idle", busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
